// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and default sizing for the PWM duty sequencer slice.
//   pwm_state_e : sequencer FSM state (IDLE, RAMP)
//   pwm_step_e  : pending single-step request (NONE, UP, DOWN)
//   *_DEF       : default parameter values used by the top level
//   hold_w()    : counter width able to hold STEP_HOLD-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } pwm_state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } pwm_step_e;

   localparam int DUTY_W_DEF    = 4;
   localparam int DUTY_MAX_DEF  = 10;
   localparam int DUTY_RST_DEF  = 5;
   localparam int STEP_HOLD_DEF = 4;

   // Width needed for a down-counter that reloads to step_hold-1.
   function automatic int hold_w(input int step_hold);
      if (step_hold <= 2) return 1;
      return $clog2(step_hold);
   endfunction

endpackage

// File: rtl/pwm_hold_timer.sv
// -----------------------------------------------------------------------------
// pwm_hold_timer
// Period-count down-counter that spaces ramp steps apart.
//   clk, rst_n : clock, asynchronous active-high reset (count -> 0)
//   i_clr      : synchronous clear to 0 (ramp entry, so the first step is
//                taken at the first qualifying period boundary)
//   i_tick     : one qualifying period boundary (ena & period_end in RAMP);
//                reloads to LOAD when already zero, otherwise decrements
//   o_zero     : count is zero, i.e. a step is due on this tick
// -----------------------------------------------------------------------------
module pwm_hold_timer #(
   parameter int             W    = 2,
   parameter logic [W-1:0]   LOAD = '0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_tick,
   output logic o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_tick) begin
         if (r_count == '0) r_count <= LOAD;
         else               r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_duty_sequencer
// Owns the duty register feeding the PWM core. Single-step inc/dec requests
// and absolute target loads are arbitrated; loads are reached by a
// rate-limited ramp. Every duty change is committed on a PWM period boundary.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-high reset
//   ena          : block enable, 0 freezes all state (pending step retained)
//   period_end   : one-cycle pulse on the last count of each PWM period
//   inc_pulse    : single-cycle step-up request
//   dec_pulse    : single-cycle step-down request
//   tgt_valid    : target load request
//   tgt_data     : requested duty
//   tgt_ready    : combinational, ena & IDLE
//   duty         : registered duty value
//   duty_upd     : registered pulse in the first cycle duty shows a new value
//   busy         : registered, high while ramping
//   clamp_err    : registered pulse when an accepted target exceeded DUTY_MAX
//   dbg_state    : current FSM state
//
// Handshake: a target transfers in any cycle where tgt_valid & tgt_ready are
// both high at the rising clock edge; tgt_valid may be asserted without waiting
// for tgt_ready, and tgt_ready does not depend on tgt_valid.
//
// Build option: PWM_SEQ_SOFTSTART_EN -- when defined the block leaves reset at
// duty 0 already ramping toward DUTY_RST (busy=1, tgt_ready=0). When undefined
// it leaves reset idle at duty DUTY_RST.
// -----------------------------------------------------------------------------
module pwm_duty_sequencer
   import pwm_pkg::*;
#(
   parameter int DUTY_W    = DUTY_W_DEF,
   parameter int DUTY_MAX  = DUTY_MAX_DEF,
   parameter int DUTY_RST  = DUTY_RST_DEF,
   parameter int STEP_HOLD = STEP_HOLD_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              period_end,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
   input  logic              tgt_valid,
   input  logic [DUTY_W-1:0] tgt_data,
   output logic              tgt_ready,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_upd,
   output logic              busy,
   output logic              clamp_err,
   output pwm_state_e        dbg_state
);

   localparam int                 HOLD_W       = hold_w(STEP_HOLD);
   localparam logic [HOLD_W-1:0]  LP_HOLD_LOAD = HOLD_W'(STEP_HOLD - 1);
   localparam logic [DUTY_W-1:0]  LP_MAX       = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0]  LP_RST       = DUTY_W'(DUTY_RST);

`ifdef PWM_SEQ_SOFTSTART_EN
   localparam pwm_state_e         LP_STATE0 = RAMP;
   localparam logic [DUTY_W-1:0]  LP_DUTY0  = '0;
   localparam logic               LP_BUSY0  = 1'b1;
`else
   localparam pwm_state_e         LP_STATE0 = IDLE;
   localparam logic [DUTY_W-1:0]  LP_DUTY0  = LP_RST;
   localparam logic               LP_BUSY0  = 1'b0;
`endif

   // State
   pwm_state_e        r_state;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] r_target;
   pwm_step_e         r_pending;
   logic              r_duty_upd;
   logic              r_busy;
   logic              r_clamp_err;

   // Next-state and control
   pwm_state_e        w_state_nxt;
   logic [DUTY_W-1:0] w_duty_nxt;
   logic [DUTY_W-1:0] w_target_nxt;
   pwm_step_e         w_pending_nxt;
   logic              w_upd_nxt;
   logic              w_clamp_nxt;
   logic              w_hold_clr;
   logic              w_hold_tick;
   logic              w_hold_zero;

   // Saturating neighbours of the current duty
   logic [DUTY_W-1:0] w_duty_inc;
   logic [DUTY_W-1:0] w_duty_dec;
   logic [DUTY_W-1:0] w_duty_toward;
   logic [DUTY_W-1:0] w_duty_step;

   assign w_duty_inc    = (r_duty >= LP_MAX) ? LP_MAX : (r_duty + DUTY_W'(1));
   assign w_duty_dec    = (r_duty == '0)     ? '0     : (r_duty - DUTY_W'(1));
   assign w_duty_toward = (r_target > r_duty) ? w_duty_inc : w_duty_dec;

   always_comb begin
      w_duty_step = r_duty;
      case (r_pending)
         UP:      w_duty_step = w_duty_inc;
         DOWN:    w_duty_step = w_duty_dec;
         default: w_duty_step = r_duty;
      endcase
   end

   pwm_hold_timer #(
      .W    (HOLD_W),
      .LOAD (LP_HOLD_LOAD)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_hold_clr),
      .i_tick (w_hold_tick),
      .o_zero (w_hold_zero)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_duty_nxt    = r_duty;
      w_target_nxt  = r_target;
      w_pending_nxt = r_pending;
      w_upd_nxt     = 1'b0;
      w_clamp_nxt   = 1'b0;
      w_hold_clr    = 1'b0;
      w_hold_tick   = 1'b0;

      if (ena) begin
         case (r_state)
            IDLE: begin
               if (tgt_valid) begin
                  // Load wins over any coincident or pending step request.
                  w_target_nxt  = (tgt_data > LP_MAX) ? LP_MAX : tgt_data;
                  w_clamp_nxt   = (tgt_data > LP_MAX);
                  w_pending_nxt = NONE;
                  w_hold_clr    = 1'b1;
                  w_state_nxt   = RAMP;
               end else begin
                  if (period_end) begin
                     w_duty_nxt    = w_duty_step;
                     w_upd_nxt     = (w_duty_step != r_duty);
                     w_pending_nxt = NONE;
                  end
                  // A pulse coincident with period_end is kept for the
                  // following boundary, so it overrides the clear above.
                  if (inc_pulse && !dec_pulse)      w_pending_nxt = UP;
                  else if (dec_pulse && !inc_pulse) w_pending_nxt = DOWN;
               end
            end

            RAMP: begin
               if (r_duty == r_target) begin
                  // Target already reached on entry: leave without an update.
                  w_state_nxt = IDLE;
               end else if (period_end) begin
                  w_hold_tick = 1'b1;
                  if (w_hold_zero) begin
                     w_duty_nxt = w_duty_toward;
                     w_upd_nxt  = 1'b1;
                     if (w_duty_toward == r_target) w_state_nxt = IDLE;
                  end
               end
            end

            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state     <= LP_STATE0;
         r_duty      <= LP_DUTY0;
         r_target    <= LP_RST;
         r_pending   <= NONE;
         r_duty_upd  <= 1'b0;
         r_busy      <= LP_BUSY0;
         r_clamp_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_duty      <= w_duty_nxt;
         r_target    <= w_target_nxt;
         r_pending   <= w_pending_nxt;
         r_duty_upd  <= w_upd_nxt;
         r_busy      <= (w_state_nxt == RAMP);
         r_clamp_err <= w_clamp_nxt;
      end
   end

   assign tgt_ready = ena & (r_state == IDLE);
   assign duty      = r_duty;
   assign duty_upd  = r_duty_upd;
   assign busy      = r_busy;
   assign clamp_err = r_clamp_err;
   assign dbg_state = r_state;

endmodule
